// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus a 32-byte MMIO window holding a
// GPIO port and a 32-bit compare timer with a level interrupt.
// Loads are combinational from addr and current state; stores land on the
// rising clk edge.
// Optional feature macro: DMEM_MMIO_GPIO_SYNC_EN. When it is defined,
// gpio_in goes through a 2-flop synchronizer before GPIO_IN reads it.
module dmem_mmio #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0800,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_dm,
    input  logic [31:0]       addr,
    input  logic [31:0]       wd_dm,
    output logic [31:0]       rd_dm,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);

    // Register selects inside the MMIO window (word offset addr[4:2]).
    localparam logic [2:0] R_GPIO_OUT = 3'd0;
    localparam logic [2:0] R_GPIO_IN  = 3'd1;
    localparam logic [2:0] R_TCNT     = 3'd2;
    localparam logic [2:0] R_TCMP     = 3'd3;
    localparam logic [2:0] R_TCTRL    = 3'd4;

    // Byte lanes are not supported, so the low two address bits are dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    // Address decode. DEPTH is a power of two, so "addr < DEPTH*4" is the
    // same as all address bits above the word index being zero.
    logic          ram_sel;
    logic          mmio_sel;
    logic [2:0]    reg_sel;
    logic [AW-1:0] ram_idx;

    assign ram_sel  = (addr[31:AW+2] == '0);
    assign mmio_sel = (addr[31:5] == MMIO_BASE[31:5]);
    assign reg_sel  = addr[4:2];
    assign ram_idx  = addr[AW+1:2];

    // ---------------------------------------------------------------- RAM
    logic [31:0] mem [DEPTH];

    // RAM write. This is not gated by rst, so a store during reset still lands.
    always_ff @(posedge clk) begin
        if (we_dm && ram_sel)
            mem[ram_idx] <= wd_dm;
    end

    // ------------------------------------------------------- GPIO input path
    logic [GPIO_W-1:0] gpio_rd;

`ifdef DMEM_MMIO_GPIO_SYNC_EN
    logic [GPIO_W-1:0] gpio_s1, gpio_s2;

    // Two-flop synchronizer for the external pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end
    assign gpio_rd = gpio_s2;
`else
    assign gpio_rd = gpio_in;
`endif

    // ------------------------------------------------------ MMIO registers
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       tcnt_q, tcnt_d;
    logic [31:0]       tcmp_q, tcmp_d;
    logic              en_q, en_d;
    logic              arl_q, arl_d;
    logic              flag_q, flag_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;

    logic wr_mmio, wr_gpio, wr_tcnt, wr_tcmp, wr_tctrl, match;

    assign wr_mmio  = we_dm && mmio_sel;
    assign wr_gpio  = wr_mmio && (reg_sel == R_GPIO_OUT);
    assign wr_tcnt  = wr_mmio && (reg_sel == R_TCNT);
    assign wr_tcmp  = wr_mmio && (reg_sel == R_TCMP);
    assign wr_tctrl = wr_mmio && (reg_sel == R_TCTRL);
    assign match    = en_q && (tcnt_q == tcmp_q);

    // Next-state for the registers and the timer. A TCNT write outranks a
    // match, so a match that coincides with a TCNT write does not set FLAG.
    // A FLAG set outranks a W1C clear in the same cycle.
    always_comb begin
        gpio_d   = wr_gpio ? wd_dm[GPIO_W-1:0] : gpio_q;
        tcmp_d   = wr_tcmp ? wd_dm : tcmp_q;
        en_d     = wr_tctrl ? wd_dm[0] : en_q;
        arl_d    = wr_tctrl ? wd_dm[1] : arl_q;
        irq_en_d = wr_tctrl ? wd_dm[3] : irq_en_q;
        tcnt_d   = tcnt_q;
        flag_d   = flag_q;

        if (wr_tctrl && wd_dm[2])
            flag_d = 1'b0;

        if (wr_tcnt) begin
            tcnt_d = wd_dm;
        end else if (match) begin
            flag_d = 1'b1;
            tcnt_d = arl_q ? 32'd0 : tcnt_q + 32'd1;
        end else if (en_q) begin
            tcnt_d = tcnt_q + 32'd1;
        end

        // irq follows the post-edge FLAG and IRQ_EN, so it rises on the same
        // edge that sets FLAG.
        irq_d = flag_d && irq_en_d;
    end

    // Register update. While rst is high, all MMIO state is cleared and any
    // store to MMIO is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q   <= '0;
            tcnt_q   <= '0;
            tcmp_q   <= '0;
            en_q     <= 1'b0;
            arl_q    <= 1'b0;
            flag_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            tcnt_q   <= tcnt_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            arl_q    <= arl_d;
            flag_q   <= flag_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_out = gpio_q;
    assign irq      = irq_q;

    // Load mux. Unmapped addresses and unused MMIO slots read as zero.
    always_comb begin
        rd_dm = '0;
        if (ram_sel) begin
            rd_dm = mem[ram_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                R_GPIO_OUT: rd_dm = 32'(gpio_q);
                R_GPIO_IN:  rd_dm = 32'(gpio_rd);
                R_TCNT:     rd_dm = tcnt_q;
                R_TCMP:     rd_dm = tcmp_q;
                R_TCTRL:    rd_dm = {28'd0, irq_en_q, flag_q, arl_q, en_q};
                default:    rd_dm = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio. The stimulus side pushes hand-computed
// expectations for the current cycle. A monitor drains the queue on each
// falling edge and compares the expectations against the DUT outputs.
module tb_dmem_mmio;
    localparam int GW = 8;

    localparam logic [31:0] A_GOUT  = 32'h800;
    localparam logic [31:0] A_GIN   = 32'h804;
    localparam logic [31:0] A_TCNT  = 32'h808;
    localparam logic [31:0] A_TCMP  = 32'h80C;
    localparam logic [31:0] A_TCTRL = 32'h810;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we_dm = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wd_dm = '0;
    logic [31:0]   rd_dm;
    logic [GW-1:0] gpio_in = '0;
    logic [GW-1:0] gpio_out;
    logic          irq;

    dmem_mmio #(.DEPTH(256), .MMIO_BASE(32'h0000_0800), .GPIO_W(GW)) dut (
        .clk(clk), .rst(rst), .we_dm(we_dm), .addr(addr), .wd_dm(wd_dm),
        .rd_dm(rd_dm), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd_dm, 1 = gpio_out, 2 = irq
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = rd_dm;
                1:       act = 32'(gpio_out);
                default: act = {31'd0, irq};
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h want 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int kind, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_dm = 1'b1;
        addr  = a;
        wd_dm = d;
        tick();
        we_dm = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
        addr = a;
        expect_v(0, v, n);
        tick();
    endtask

    // Read TCNT and check irq in the same cycle.
    task automatic rd_t(input logic [31:0] v, input logic i, input string n);
        addr = A_TCNT;
        expect_v(0, v, n);
        expect_v(2, {31'd0, i}, {n, "_irq"});
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        addr = A_TCNT;
        expect_v(0, 32'd0, "rst_tcnt");
        expect_v(1, 32'd0, "rst_gpio_out");
        expect_v(2, 32'd0, "rst_irq");
        tick();
        rd(A_TCTRL, 32'd0, "rst_tctrl");

        // ---------------- RAM
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h13, 32'hDEAD_BEEF, "ram_rd_unaligned");
        rd(32'h400, 32'd0, "oor_rd");
        wr(32'h400, 32'h1234_5678);
        rd(32'h10, 32'hDEAD_BEEF, "ram_after_oor_wr");
        wr(32'h14, 32'd1);
        we_dm = 1'b1;
        addr  = 32'h14;
        wd_dm = 32'd2;
        expect_v(0, 32'd1, "ram_same_cycle_old");
        tick();
        we_dm = 1'b0;
        rd(32'h14, 32'd2, "ram_next_cycle_new");

        // ---------------- GPIO
        wr(A_GOUT, 32'h1A5);
        addr = A_GOUT;
        expect_v(1, 32'hA5, "gpio_out_pin");
        expect_v(0, 32'hA5, "gpio_out_rd");
        tick();
        gpio_in = 8'h3C;
`ifdef DMEM_MMIO_GPIO_SYNC_EN
        rd(A_GIN, 32'd0, "gpio_in_sync0");
        rd(A_GIN, 32'd0, "gpio_in_sync1");
`endif
        rd(A_GIN, 32'h3C, "gpio_in_rd");
        wr(A_GIN, 32'hFF);
        rd(A_GIN, 32'h3C, "gpio_in_ro");
        rd(32'h814, 32'd0, "mmio_hole");
        rd(32'h900, 32'd0, "unmapped");

        // ---------------- timer, autoreload + irq
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'hB);
        rd_t(32'd0, 1'b0, "t0");
        rd_t(32'd1, 1'b0, "t1");
        rd_t(32'd2, 1'b0, "t2");
        rd_t(32'd3, 1'b0, "t3");
        rd_t(32'd4, 1'b0, "t4");
        rd_t(32'd5, 1'b0, "t5");
        rd_t(32'd0, 1'b1, "t6_reload");
        rd_t(32'd1, 1'b1, "t7");
        // tcnt=2: W1C the flag
        expect_v(2, 32'd1, "irq_before_w1c");
        wr(A_TCTRL, 32'hF);
        addr = A_TCTRL;
        expect_v(0, 32'hB, "tctrl_after_w1c");
        expect_v(2, 32'd0, "irq_after_w1c");
        tick();
        rd_t(32'd4, 1'b0, "t10");
        rd_t(32'd5, 1'b0, "t11");
        addr = A_TCTRL;
        expect_v(0, 32'hF, "tctrl_rematch");
        expect_v(2, 32'd1, "irq_rematch");
        tick();
        // tcnt=1..4 then W1C at the match (tcnt=5); the set must win
        rd_t(32'd1, 1'b1, "t13");
        rd_t(32'd2, 1'b1, "t14");
        rd_t(32'd3, 1'b1, "t15");
        rd_t(32'd4, 1'b1, "t16");
        wr(A_TCTRL, 32'hF);
        addr = A_TCTRL;
        expect_v(0, 32'hF, "w1c_vs_set");
        expect_v(2, 32'd1, "w1c_vs_set_irq");
        tick();
        // tcnt=1: clear the flag, then write TCNT at the next match
        wr(A_TCTRL, 32'hF);
        rd_t(32'd2, 1'b0, "t20");
        rd_t(32'd3, 1'b0, "t21");
        rd_t(32'd4, 1'b0, "t22");
        wr(A_TCNT, 32'h100);
        addr = A_TCTRL;
        expect_v(0, 32'hB, "tcnt_wr_vs_match_flag");
        expect_v(2, 32'd0, "tcnt_wr_vs_match_irq");
        tick();
        rd(A_TCNT, 32'h101, "tcnt_wr_loaded");

        // ---------------- timer, no autoreload, wrap, irq disabled
        wr(A_TCTRL, 32'h4);
        wr(A_TCMP, 32'd0);
        wr(A_TCNT, 32'hFFFF_FFFE);
        wr(A_TCTRL, 32'h1);
        rd_t(32'hFFFF_FFFE, 1'b0, "w0");
        rd_t(32'hFFFF_FFFF, 1'b0, "w1");
        rd_t(32'd0, 1'b0, "w2_wrap");
        addr = A_TCTRL;
        expect_v(0, 32'h5, "wrap_flag");
        expect_v(2, 32'd0, "wrap_irq_off");
        tick();
        rd_t(32'd2, 1'b0, "w4_no_reload");

        // ---------------- reset mid-count with concurrent stores
        rst   = 1'b1;
        we_dm = 1'b1;
        addr  = A_TCNT;
        wd_dm = 32'h55;
        tick();
        addr  = 32'h20;
        wd_dm = 32'hCAFE;
        tick();
        rst   = 1'b0;
        we_dm = 1'b0;
        addr  = A_TCNT;
        expect_v(0, 32'd0, "rst2_tcnt");
        expect_v(1, 32'd0, "rst2_gpio_out");
        expect_v(2, 32'd0, "rst2_irq");
        tick();
        rd(A_TCTRL, 32'd0, "rst2_tctrl");
        rd(32'h10, 32'hDEAD_BEEF, "ram_kept");
        rd(32'h20, 32'hCAFE, "ram_wr_in_rst");

        tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
